sdram_play_fetcher: RTL and testbench

// - Initiator-side client of the SDRAM bus play read port: walks an address range
//   [start_addr..end_addr] one 16-bit sample per address, via a play_read/play_read_finished handshake.
// - Prefetches samples into a small FIFO; the audio DAC path pops one sample per frame.
// - Supports one-shot and looped playback, stop mid-stream and underrun reporting.

---
 rtl/sdram_bus_pkg.sv | 17 +
 rtl/sdram_sample_fifo.sv | 59 +++++
 rtl/sdram_play_fetcher.sv | 156 +++++++++++++++
 tb/tb_sdram_play_fetcher.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_bus_pkg.sv
// rtl/sdram_bus_pkg.sv - shared constants and FSM state type for the SDRAM play fetcher
//
// Purpose: SDRAM word address / sample widths and the fetcher state encoding.
package sdram_bus_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    DRAIN,
    ABORT
  } play_state_t;

endpackage

// File: rtl/sdram_sample_fifo.sv
// rtl/sdram_sample_fifo.sv - synchronous show-ahead sample FIFO with flush and level
//
// Purpose: holds prefetched samples between the SDRAM read port and the DAC path.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   push, push_data    write one sample (ignored when full)
//   pop                drop the head sample (ignored when empty)
//   flush              empty the FIFO; wins over push/pop
//   head               current head sample, 0 when empty
//   valid              FIFO not empty
//   level              current occupancy (0..DEPTH)
module sdram_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push, do_pop;

  assign do_push = push && (level_q != LVL_W'(DEPTH));
  assign do_pop  = pop && (level_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign valid = (level_q != '0);
  assign head  = valid ? mem_q[rd_q] : '0;
  assign level = level_q;

endmodule

// File: rtl/sdram_play_fetcher.sv
// rtl/sdram_play_fetcher.sv - walks an SDRAM address range and prefetches samples for playback
//
// Purpose: issues play_read requests over [start_addr..end_addr] (optionally looped),
// buffers returned samples in a show-ahead FIFO, and reports done / underrun.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   start, stop, loop_en            control (stop wins over start)
//   start_addr, end_addr            inclusive word address range
//   busy, done                      status (done = one-shot complete and drained)
//   play_read, play_addr            bus request, held until play_read_finished
//   play_readdata, play_read_finished  bus completion
//   sample_pop, sample_data, sample_valid  consumer side of the FIFO
//   underrun                        pop attempted on empty FIFO while busy
//   fifo_level                      FIFO occupancy
module sdram_play_fetcher #(
  parameter int ADDR_W = sdram_bus_pkg::ADDR_W,
  parameter int DATA_W = sdram_bus_pkg::DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [ADDR_W-1:0]      end_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   play_read,
  output logic [ADDR_W-1:0]      play_addr,
  input  logic [DATA_W-1:0]      play_readdata,
  input  logic                   play_read_finished,
  input  logic                   sample_pop,
  output logic [DATA_W-1:0]      sample_data,
  output logic                   sample_valid,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  import sdram_bus_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  play_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              loop_q, loop_d;
  logic              underrun_q;
  logic              fifo_push, fifo_flush, pop_eff;
  logic [LVL_W-1:0]  level_after;

  assign pop_eff     = sample_pop && sample_valid;
  assign level_after = fifo_level - LVL_W'(pop_eff);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    start_d    = start_q;
    end_d      = end_q;
    loop_d     = loop_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && (start_addr <= end_addr)) begin
          state_d = REQ;
          cur_d   = start_addr;
          start_d = start_addr;
          end_d   = end_addr;
          loop_d  = loop_en;
        end
      end
      REQ: begin
        if (stop) begin
          fifo_flush = 1'b1;
          // A request completing in the stop cycle has nothing left to wait for.
          state_d = play_read_finished ? IDLE : ABORT;
        end else if (play_read_finished) begin
          fifo_push = 1'b1;
          if (cur_q == end_q && !loop_q) begin
            state_d = DRAIN;
          end else begin
            // Equality test rather than cur+1 > end keeps the top address safe from wrap.
            cur_d   = (cur_q == end_q) ? start_q : cur_q + ADDR_W'(1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (stop) begin
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (level_after < LVL_W'(DEPTH)) begin
          // Room for the sample the next request will return.
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (stop) begin
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else if (fifo_level == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ABORT: begin
        // Bus request cannot be withdrawn; wait it out and drop the data.
        fifo_flush = 1'b1;
        if (play_read_finished) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      start_q    <= '0;
      end_q      <= '0;
      loop_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      start_q    <= start_d;
      end_q      <= end_d;
      loop_q     <= loop_d;
      underrun_q <= sample_pop && !sample_valid && busy;
    end
  end

  assign busy      = (state_q != IDLE);
  assign play_read = (state_q == REQ) || (state_q == ABORT);
  assign play_addr = play_read ? cur_q : '0;
  assign underrun  = underrun_q;

  sdram_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (play_readdata),
    .pop       (sample_pop),
    .flush     (fifo_flush),
    .head      (sample_data),
    .valid     (sample_valid),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_sdram_play_fetcher.sv
// tb/tb_sdram_play_fetcher.sv - self-checking bench for sdram_play_fetcher
module tb_sdram_play_fetcher;

  localparam longint MASK = 64'h7FFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, loop_en;
  logic [22:0] start_addr, end_addr;
  logic        busy, done, play_read;
  logic [22:0] play_addr;
  logic [15:0] play_readdata;
  logic        play_read_finished;
  logic        sample_pop;
  logic [15:0] sample_data;
  logic        sample_valid, underrun;
  logic [3:0]  fifo_level;

  always #5 clk = ~clk;

  sdram_play_fetcher dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stop               (stop),
    .loop_en            (loop_en),
    .start_addr         (start_addr),
    .end_addr           (end_addr),
    .busy               (busy),
    .done               (done),
    .play_read          (play_read),
    .play_addr          (play_addr),
    .play_readdata      (play_readdata),
    .play_read_finished (play_read_finished),
    .sample_pop         (sample_pop),
    .sample_data        (sample_data),
    .sample_valid       (sample_valid),
    .underrun           (underrun),
    .fifo_level         (fifo_level)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] q[$];
  bit          exp_ur;
  bit          rsp_active;
  int          rsp_cnt, rsp_lat;
  logic [22:0] rsp_addr;
  int          req_cnt, pop_cnt, done_cnt, fin_cyc;
  longint      m_start, m_end;
  bit          m_loop, discard, pop_en;
  int          pop_pct;
  logic [15:0] key;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] memf(input logic [22:0] a);
    return a[15:0] ^ key;
  endfunction

  task automatic cycle(input bit do_start, input bit do_stop);
    longint len, off;
    @(negedge clk);
    cyc++;
    chk("level", fifo_level, q.size());
    chk("valid", sample_valid, q.size() != 0);
    chk("data", sample_data, (q.size() != 0) ? q[0] : 16'h0);
    chk("underrun", underrun, exp_ur);
    if (done) done_cnt++;
    start = do_start;
    stop  = do_stop;
    if (do_start && !do_stop && !busy && start_addr <= end_addr) begin
      m_start = start_addr; m_end = end_addr; m_loop = loop_en;
      req_cnt = 0; discard = 0;
    end
    if (do_stop && busy) discard = 1;
    sample_pop = pop_en && ($urandom_range(99) < pop_pct);
    exp_ur = sample_pop && q.size() == 0 && busy;
    if (sample_pop && q.size() != 0) begin
      void'(q.pop_front());
      pop_cnt++;
    end
    play_read_finished = 0;
    if (rsp_active) begin
      chk("req_hold", play_read, 1);
      chk("addr_hold", play_addr, rsp_addr);
      rsp_cnt++;
      if (rsp_cnt >= rsp_lat) begin
        play_read_finished = 1;
        play_readdata = memf(rsp_addr);
        rsp_active = 0;
        fin_cyc = cyc;
        if (!discard) q.push_back(memf(rsp_addr));
      end
    end else if (play_read) begin
      len = m_end - m_start + 1;
      off = m_loop ? (req_cnt % len) : req_cnt;
      if (!m_loop) chk("req_in_range", req_cnt < len, 1);
      chk("req_addr", play_addr, (m_start + off) & MASK);
      rsp_active = 1; rsp_addr = play_addr; rsp_cnt = 0; req_cnt++;
    end
    if (discard) q.delete();
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle(0, 0);
      if (!busy) break;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; stop = 0; sample_pop = 0; play_read_finished = 0;
    rsp_active = 0; q.delete(); exp_ur = 0;
    @(negedge clk);
    cyc++;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", play_read, 0);
    chk("rst_addr", play_addr, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1;
  endtask

  task automatic set_range(input logic [22:0] s, input logic [22:0] e, input bit lp);
    start_addr = s; end_addr = e; loop_en = lp;
    req_cnt = 0; pop_cnt = 0; done_cnt = 0; fin_cyc = -1;
  endtask

  initial begin
    rst_n = 0; start = 0; stop = 0; loop_en = 0; start_addr = 0; end_addr = 0;
    play_readdata = 0; play_read_finished = 0; sample_pop = 0;
    exp_ur = 0; rsp_active = 0; rsp_lat = 3; key = 0; pop_en = 0; pop_pct = 100;
    discard = 0; m_start = 0; m_end = 0; m_loop = 0;
    do_reset();

    // One-shot 0x100..0x103 with latency checks on the first sample.
    set_range(23'h100, 23'h103, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("lat_start", play_read, 1);
    chk("lat_addr", play_addr, 23'h100);
    for (int i = 0; i < 10 && !play_read_finished; i++) cycle(0, 0);
    chk("fin_seen", play_read_finished, 1);
    cycle(0, 0);
    chk("lat_valid", sample_valid, 1);
    chk("lat_gap", play_read, 0);
    cycle(0, 0);
    chk("lat_next_req", play_read, 1);
    pop_en = 1; pop_pct = 100;
    run_until_idle(200);
    chk("os_reqs", req_cnt, 4);
    chk("os_pops", pop_cnt, 4);
    chk("os_done", done_cnt, 1);
    chk("os_level", fifo_level, 0);

    // Backpressure 0x0..0x1F, no consumer.
    pop_en = 0;
    set_range(23'h0, 23'h1F, 0);
    cycle(1, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0);
    chk("bp_level", fifo_level, 8);
    chk("bp_idle_bus", play_read, 0);
    chk("bp_reqs", req_cnt, 8);
    pop_en = 1;
    cycle(0, 0);
    pop_en = 0;
    for (int i = 0; i < 30; i++) cycle(0, 0);
    chk("bp_one_more", req_cnt, 9);
    chk("bp_level2", fifo_level, 8);
    cycle(0, 1);
    run_until_idle(20);
    chk("bp_flushed", sample_valid, 0);
    chk("bp_no_done", done_cnt, 0);

    // Loop 0x10..0x11.
    pop_en = 1; pop_pct = 100;
    set_range(23'h10, 23'h11, 1);
    cycle(1, 0);
    for (int i = 0; i < 60; i++) cycle(0, 0);
    chk("loop_many", req_cnt > 8, 1);
    chk("loop_busy", busy, 1);
    chk("loop_no_done", done_cnt, 0);
    loop_en = 0;
    cycle(0, 1);
    run_until_idle(20);
    chk("loop_stop_valid", sample_valid, 0);
    chk("loop_stop_done", done_cnt, 0);

    // Stop while a request is outstanding.
    pop_en = 0;
    set_range(23'h200, 23'h20F, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("ab_req", play_read, 1);
    cycle(0, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0);
      if (!busy) break;
    end
    chk("ab_idle", busy, 0);
    chk("ab_idle_cycle", cyc, fin_cyc + 1);
    chk("ab_valid", sample_valid, 0);
    chk("ab_no_done", done_cnt, 0);

    // Underrun on empty pop while busy.
    set_range(23'h300, 23'h303, 0);
    cycle(1, 0);
    pop_en = 1; pop_pct = 100;
    cycle(0, 0);
    pop_en = 0;
    cycle(0, 0);
    chk("ur_pulse", underrun, 1);
    cycle(0, 0);
    chk("ur_clear", underrun, 0);
    pop_en = 1;
    run_until_idle(200);
    chk("ur_done", done_cnt, 1);

    // Reversed range and start+stop are ignored.
    set_range(23'h20, 23'h10, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("rev_ignored", busy, 0);
    set_range(23'h20, 23'h30, 0);
    cycle(1, 1);
    cycle(0, 0);
    chk("startstop_ignored", busy, 0);

    // Reset while a request is outstanding, then a fresh run.
    set_range(23'h400, 23'h40F, 0);
    cycle(1, 0);
    cycle(0, 0);
    chk("rr_req", play_read, 1);
    do_reset();
    key = 16'($urandom);
    set_range(23'h500, 23'h502, 0);
    cycle(1, 0);
    run_until_idle(200);
    chk("rr_reqs", req_cnt, 3);
    chk("rr_done", done_cnt, 1);

    // Randomised one-shot runs, first one ending at the top address.
    for (int t = 0; t < 6; t++) begin
      int len;
      longint s;
      len = $urandom_range(1, 10);
      s = (t == 0) ? (MASK - len + 1) : longint'($urandom_range(0, 32'h7FFFFF - len + 1));
      key = 16'($urandom);
      pop_pct = $urandom_range(20, 100);
      rsp_lat = $urandom_range(1, 5);
      pop_en = 1;
      set_range(23'(s), 23'(s + len - 1), 0);
      cycle(1, 0);
      run_until_idle(600);
      chk("rnd_reqs", req_cnt, len);
      chk("rnd_pops", pop_cnt, len);
      chk("rnd_done", done_cnt, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
